// File: rtl/sh7604_bsc_lite.sv
// ---------------------------------------------------------------------------
// sh7604_bsc_lite
// Purpose: DBUS slave of the bus state controller. It turns DBUS requests to
// the external areas (A[31:29] = 000/001) into SRAM-style bus cycles
// T1, Tw*n, T2. It also handles 4-beat long-word bursts and locked
// back-to-back transfers, where chip select stays low between accesses.
//
// Optional feature: define BSC_IDLE_CYCLE_EN to insert one idle CE_R cycle,
// with CS high, when a locked read is followed by a write.
//
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   CE_R, CE_F        rising / falling phase enables (state moves on CE_R)
//   DBUS_A/DI/BA/WE   request address, write data, byte lanes, direction
//   DBUS_REQ          request valid
//   DBUS_BURST/LOCK   burst beat marker, keep-CS-after-beat marker
//   DBUS_DO           read data (captured on entry to T2)
//   DBUS_WAIT         access not yet complete
//   BSC_ACK           high in T2 of a claimed beat
//   WCR               wait states per area, 2 bits each
//   BUS_ERR           sticky external-wait timeout flag
//   MEM_A/DO/DI       external address / write data / read data
//   MEM_CS_N          per-area chip selects (area = DBUS_A[26:25])
//   MEM_RD_N/WE_N     read strobe, per-lane write strobes
//   MEM_WAIT_N        external wait, honoured only for 3-wait-state areas
//   o_dbg_state       current FSM state (state_t encoding)
//
// Handshake: DBUS_REQ is the master's valid. DBUS_WAIT acts as an inverted
// ready: a beat completes in the cycle where DBUS_REQ=1 and DBUS_WAIT=0,
// which is the T2 cycle. The master samples DBUS_WAIT on CE_F and then
// presents its next beat before the following CE_R.
// ---------------------------------------------------------------------------
module sh7604_bsc_lite #(
  parameter int EXT_AW  = 27,
  parameter int MAX_EXT = 15
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE_R,
  input  logic              CE_F,
  input  logic [31:0]       DBUS_A,
  input  logic [31:0]       DBUS_DI,
  output logic [31:0]       DBUS_DO,
  input  logic [3:0]        DBUS_BA,
  input  logic              DBUS_WE,
  input  logic              DBUS_REQ,
  input  logic              DBUS_BURST,
  input  logic              DBUS_LOCK,
  output logic              DBUS_WAIT,
  output logic              BSC_ACK,
  input  logic [7:0]        WCR,
  output logic              BUS_ERR,
  output logic [EXT_AW-1:0] MEM_A,
  output logic [31:0]       MEM_DO,
  input  logic [31:0]       MEM_DI,
  output logic [3:0]        MEM_CS_N,
  output logic              MEM_RD_N,
  output logic [3:0]        MEM_WE_N,
  input  logic              MEM_WAIT_N,
  output logic [2:0]        o_dbg_state
);

  localparam int EXT_W = $clog2(MAX_EXT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_TW   = 3'd2,
    S_T2   = 3'd3,
    S_HOLD = 3'd4,
    S_TI   = 3'd5   // read-to-write turnaround, reachable only with BSC_IDLE_CYCLE_EN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_area;
  logic [1:0]        r_w;
  logic [1:0]        r_cnt;
  logic [EXT_W-1:0]  r_ext;
  logic [1:0]        r_beat;
  logic              r_we;
  logic [3:0]        r_ba;
  logic              r_burst;
  logic              r_lock;
  logic [EXT_AW-1:0] r_mem_a;
  logic [31:0]       r_mem_do;
  logic [31:0]       r_dbus_do;
  logic              r_bus_err;

  logic              w_hit;
  logic              w_same;
  logic [1:0]        w_wcr_w;
  logic              w_cont;
  logic              w_hold;
  logic              w_latch;
  logic              w_err_set;
  logic              w_we_eff;
  logic              w_cs_act;
  logic              w_strb;
  logic              w_unused;

  // Only the external areas are claimed; everything else belongs to other slaves.
  assign w_hit   = DBUS_REQ & ((DBUS_A[31:29] == 3'b000) | (DBUS_A[31:29] == 3'b001));
  assign w_same  = (DBUS_A[26:25] == r_area);
  assign w_wcr_w = WCR[{DBUS_A[26:25], 1'b0} +: 2];

  // Burst continues only while the master keeps requesting the same area.
  assign w_cont  = r_burst & (r_beat != 2'd3) & w_hit & w_same;
  // Chip select is kept across the gap for a lock, or for a burst whose next
  // beat is not yet presented. A dropped request ends an unlocked burst.
  assign w_hold  = r_lock | (r_burst & (r_beat != 2'd3) & DBUS_REQ);

  // Direction of the beat that the coming CE_R edge leads into.
  assign w_we_eff = w_latch ? DBUS_WE : r_we;

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          w_state_nxt = S_T1;
          w_latch     = 1'b1;
        end
      end
      S_T1: begin
        w_state_nxt = (r_w != 2'd0) ? S_TW : S_T2;
      end
      S_TW: begin
        if (r_cnt != 2'd0) begin
          w_state_nxt = S_TW;
        end else if ((r_w == 2'd3) && !MEM_WAIT_N) begin
          // Extension phase. Give up after MAX_EXT extra cycles.
          if (r_ext == EXT_W'(MAX_EXT)) begin
            w_err_set   = 1'b1;
            w_state_nxt = S_T2;
          end
        end else begin
          w_state_nxt = S_T2;
        end
      end
      S_T2: begin
        if (w_cont) begin
          w_latch     = 1'b1;
          w_state_nxt = (r_w != 2'd0) ? S_TW : S_T2;
        end else if (w_hold) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        if (w_hit && w_same) begin
          w_latch = 1'b1;
`ifdef BSC_IDLE_CYCLE_EN
          if (DBUS_WE && !r_we) begin
            w_state_nxt = S_TI;
          end else begin
            w_state_nxt = (r_w != 2'd0) ? S_TW : S_T2;
          end
`else
          w_state_nxt = (r_w != 2'd0) ? S_TW : S_T2;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_TI: begin
        w_state_nxt = (r_w != 2'd0) ? S_TW : S_T2;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_area    <= 2'd0;
      r_w       <= 2'd0;
      r_cnt     <= 2'd0;
      r_ext     <= '0;
      r_beat    <= 2'd0;
      r_we      <= 1'b0;
      r_ba      <= 4'd0;
      r_burst   <= 1'b0;
      r_lock    <= 1'b0;
      r_mem_a   <= '0;
      r_mem_do  <= 32'd0;
      r_dbus_do <= 32'd0;
      r_bus_err <= 1'b0;
    end else if (CE_R) begin
      r_state <= w_state_nxt;

      if (w_latch) begin
        r_mem_a  <= DBUS_A[EXT_AW-1:0];
        r_mem_do <= DBUS_DI;
        r_we     <= DBUS_WE;
        r_ba     <= DBUS_BA;
        r_burst  <= DBUS_BURST;
        r_lock   <= DBUS_LOCK;
      end

      // Area and wait count are fixed for the whole chain of beats that
      // starts with this T1, so WCR changes only affect the next T1.
      if ((r_state == S_IDLE) && w_latch) begin
        r_area <= DBUS_A[26:25];
        r_w    <= w_wcr_w;
      end

      if ((r_state == S_T2) && w_latch) begin
        r_beat <= r_beat + 2'd1;
      end else if (w_latch || (r_state == S_T2)) begin
        r_beat <= 2'd0;
      end

      if ((r_state != S_TW) && (w_state_nxt == S_TW)) begin
        r_cnt <= r_w - 2'd1;
        r_ext <= '0;
      end else if (r_state == S_TW) begin
        if (r_cnt != 2'd0) begin
          r_cnt <= r_cnt - 2'd1;
        end else if (w_state_nxt == S_TW) begin
          r_ext <= r_ext + 1'b1;
        end
      end

      if (w_err_set) begin
        r_bus_err <= 1'b1;
      end

      if ((w_state_nxt == S_T2) && !w_we_eff) begin
        r_dbus_do <= MEM_DI;
      end
    end
  end

  // Strobes and selects decode straight from the state register so that an
  // asynchronous reset releases them at once.
  assign w_cs_act = (r_state == S_T1) | (r_state == S_TW) | (r_state == S_T2) |
                    (r_state == S_HOLD);
  assign w_strb   = (r_state == S_TW) | (r_state == S_T2);

  assign MEM_CS_N    = w_cs_act ? ~(4'b0001 << r_area) : 4'hF;
  assign MEM_RD_N    = ~(w_strb & ~r_we);
  assign MEM_WE_N    = (w_strb & r_we) ? ~r_ba : 4'hF;
  assign MEM_A       = r_mem_a;
  assign MEM_DO      = r_mem_do;
  assign DBUS_DO     = r_dbus_do;
  assign BSC_ACK     = (r_state == S_T2);
  assign DBUS_WAIT   = w_hit & (r_state != S_T2);
  assign BUS_ERR     = r_bus_err;
  assign o_dbg_state = r_state;

  // CE_F only matters to the master; A[28:27] lie outside the decoded range.
  assign w_unused = ^{CE_F, DBUS_A[28:27]};

endmodule
